// File: rtl/gmii_tx_64_to_8_if.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_tx_64_to_8_if
//  Description : AXI-Stream beat bundle feeding the 64-to-8 GMII transmitter.
//                master = frame source (MAC TX datapath), slave = transmitter.
//  Signals     : tdata  - frame data, byte 0 in bits [7:0] goes first
//                tkeep  - byte enables, meaningful on the tlast beat only
//                tvalid - beat valid
//                tready - beat accepted when tvalid && tready
//                tlast  - last beat of frame
//                tuser  - on the tlast beat: frame is bad
//  Revision    : 1.0 - initial release
// ============================================================================
interface gmii_tx_64_to_8_if #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/gmii_tx_64_to_8.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_tx_64_to_8
//  Description : Serialises 64-bit AXI-Stream frames onto an 8-bit GMII TX
//                interface. Generates preamble/SFD, pads short frames,
//                appends the CRC-32 FCS and enforces the inter-frame gap.
//  Ports       : gmii_clk     - transmit clock, rising edge
//                resetn       - asynchronous active-low reset
//                s_axis       - AXI-Stream slave (gmii_tx_64_to_8_if.slave)
//                gmii_txd     - registered transmit data
//                gmii_tx_en   - registered transmit enable
//                gmii_tx_er   - registered transmit error
//                er_underflow - one-cycle pulse when the source starves
//                               mid-frame
//  Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_64_to_8 #(
   parameter int GMII_DATA_W    = 8,
   parameter int DATA_WIDTH     = 64,
   parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter bit ENABLE_PADDING = 1'b1,
   parameter int MIN_FRAME_LEN  = 60,
   parameter int IFG_LEN        = 12
) (
   input  wire                     gmii_clk,
   input  wire                     resetn,
   gmii_tx_64_to_8_if.slave        s_axis,
   output logic [GMII_DATA_W-1:0]  gmii_txd,
   output logic                    gmii_tx_en,
   output logic                    gmii_tx_er,
   output logic                    er_underflow
);

   localparam logic [15:0] MIN_LEN_C  = 16'(MIN_FRAME_LEN);
   localparam logic [15:0] IFG_LAST_C = 16'(IFG_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PREAMBLE  = 3'd1,
      ST_PAYLOAD   = 3'd2,
      ST_PAD       = 3'd3,
      ST_FCS       = 3'd4,
      ST_UNDERFLOW = 3'd5,
      ST_DISCARD   = 3'd6,
      ST_IFG       = 3'd7
   } state_t;

   // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
   function automatic logic [31:0] crc_step(input logic [31:0] crc_in, input logic [7:0] data_in);
      logic [31:0] r;
      r = crc_in ^ {24'd0, data_in};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
   logic [KEEP_WIDTH-1:0]   hold_keep_q, hold_keep_d;
   logic                    hold_last_q, hold_last_d;
   logic                    hold_user_q, hold_user_d;
   logic [2:0]              ptr_q, ptr_d;
   logic [15:0]             byte_cnt_q, byte_cnt_d;
   logic [31:0]             crc_q, crc_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [GMII_DATA_W-1:0]  gmii_txd_q, gmii_txd_d;
   logic                    gmii_tx_en_q, gmii_tx_en_d;
   logic                    gmii_tx_er_q, gmii_tx_er_d;
   logic                    er_underflow_q, er_underflow_d;

   logic                    tready_w;
   logic                    load_w;
   logic [2:0]              last_idx_w;
   logic                    keep_run_w;
   logic [GMII_DATA_W-1:0]  byte_sel_w;
   logic [15:0]             byte_cnt_inc_w;
   logic [31:0]             crc_inv_w;

   // Index of the final valid byte on a tlast beat: length of the run of ones
   // in tkeep starting at bit 0, minus one. An all-zero keep still sends one
   // byte, which falls out naturally from the default of 0.
   always_comb begin
      last_idx_w = 3'd0;
      keep_run_w = hold_keep_q[0];
      for (int i = 1; i < KEEP_WIDTH; i++) begin
         keep_run_w = keep_run_w & hold_keep_q[i];
         if (keep_run_w) begin
            last_idx_w = 3'(i);
         end
      end
   end

   assign byte_sel_w     = hold_data_q[ptr_q*GMII_DATA_W +: GMII_DATA_W];
   assign byte_cnt_inc_w = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
   assign crc_inv_w      = ~crc_q;

   // Next-state and next-output logic. Outputs are registered, so each state
   // computes what the wire must carry on the following cycle.
   always_comb begin
      state_d        = state_q;
      hold_data_d    = hold_data_q;
      hold_keep_d    = hold_keep_q;
      hold_last_d    = hold_last_q;
      hold_user_d    = hold_user_q;
      ptr_d          = ptr_q;
      byte_cnt_d     = byte_cnt_q;
      crc_d          = crc_q;
      cnt_d          = cnt_q;
      gmii_txd_d     = '0;
      gmii_tx_en_d   = 1'b0;
      gmii_tx_er_d   = 1'b0;
      er_underflow_d = 1'b0;
      tready_w       = 1'b0;
      load_w         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tready_w = 1'b1;
            if (s_axis.tvalid) begin
               load_w       = 1'b1;
               crc_d        = 32'hFFFFFFFF;
               ptr_d        = 3'd0;
               byte_cnt_d   = 16'd0;
               cnt_d        = 16'd1;
               gmii_txd_d   = GMII_DATA_W'(8'h55);
               gmii_tx_en_d = 1'b1;
               state_d      = ST_PREAMBLE;
            end
         end

         ST_PREAMBLE: begin
            gmii_tx_en_d = 1'b1;
            if (cnt_q == 16'd7) begin
               gmii_txd_d = GMII_DATA_W'(8'hD5);
               cnt_d      = 16'd0;
               state_d    = ST_PAYLOAD;
            end else begin
               gmii_txd_d = GMII_DATA_W'(8'h55);
               cnt_d      = cnt_q + 16'd1;
            end
         end

         ST_PAYLOAD: begin
            gmii_tx_en_d = 1'b1;
            gmii_txd_d   = byte_sel_w;
            crc_d        = crc_step(crc_q, byte_sel_w);
            byte_cnt_d   = byte_cnt_inc_w;
            ptr_d        = ptr_q + 3'd1;
            if (hold_last_q) begin
               if (ptr_q == last_idx_w) begin
                  ptr_d = 3'd0;
                  cnt_d = 16'd0;
                  if (ENABLE_PADDING && (byte_cnt_inc_w < MIN_LEN_C)) begin
                     state_d = ST_PAD;
                  end else begin
                     state_d = ST_FCS;
                  end
               end
            end else if (ptr_q == 3'd7) begin
               // Reload window: the next beat must be here now, or the wire
               // would have a hole in it.
               tready_w = 1'b1;
               if (s_axis.tvalid) begin
                  load_w = 1'b1;
               end else begin
                  state_d = ST_UNDERFLOW;
               end
            end
         end

         ST_PAD: begin
            gmii_tx_en_d = 1'b1;
            crc_d        = crc_step(crc_q, 8'h00);
            byte_cnt_d   = byte_cnt_inc_w;
            if (!(byte_cnt_inc_w < MIN_LEN_C)) begin
               cnt_d   = 16'd0;
               state_d = ST_FCS;
            end
         end

         ST_FCS: begin
            gmii_tx_en_d = 1'b1;
            gmii_tx_er_d = hold_user_q;
            gmii_txd_d   = GMII_DATA_W'(crc_inv_w[cnt_q[1:0]*8 +: 8]);
            if (cnt_q[1:0] == 2'd3) begin
               cnt_d   = 16'd0;
               state_d = ST_IFG;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         ST_UNDERFLOW: begin
            // Corrupt the partial frame so the far end discards it.
            gmii_tx_en_d   = 1'b1;
            gmii_tx_er_d   = 1'b1;
            er_underflow_d = 1'b1;
            cnt_d          = 16'd0;
            state_d        = hold_last_q ? ST_IFG : ST_DISCARD;
         end

         ST_DISCARD: begin
            tready_w = 1'b1;
            if (s_axis.tvalid && s_axis.tlast) begin
               cnt_d   = 16'd0;
               state_d = ST_IFG;
            end
         end

         ST_IFG: begin
            if (cnt_q == IFG_LAST_C) begin
               cnt_d   = 16'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_w) begin
         hold_data_d = s_axis.tdata;
         hold_keep_d = s_axis.tkeep;
         hold_last_d = s_axis.tlast;
         hold_user_d = s_axis.tuser;
      end
   end

   always_ff @(posedge gmii_clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         hold_data_q    <= '0;
         hold_keep_q    <= '0;
         hold_last_q    <= 1'b0;
         hold_user_q    <= 1'b0;
         ptr_q          <= 3'd0;
         byte_cnt_q     <= 16'd0;
         crc_q          <= 32'hFFFFFFFF;
         cnt_q          <= 16'd0;
         gmii_txd_q     <= '0;
         gmii_tx_en_q   <= 1'b0;
         gmii_tx_er_q   <= 1'b0;
         er_underflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         hold_data_q    <= hold_data_d;
         hold_keep_q    <= hold_keep_d;
         hold_last_q    <= hold_last_d;
         hold_user_q    <= hold_user_d;
         ptr_q          <= ptr_d;
         byte_cnt_q     <= byte_cnt_d;
         crc_q          <= crc_d;
         cnt_q          <= cnt_d;
         gmii_txd_q     <= gmii_txd_d;
         gmii_tx_en_q   <= gmii_tx_en_d;
         gmii_tx_er_q   <= gmii_tx_er_d;
         er_underflow_q <= er_underflow_d;
      end
   end

   // tready is decoded from state; hold it low while reset is asserted.
   assign s_axis.tready = tready_w & resetn;
   assign gmii_txd      = gmii_txd_q;
   assign gmii_tx_en    = gmii_tx_en_q;
   assign gmii_tx_er    = gmii_tx_er_q;
   assign er_underflow  = er_underflow_q;

endmodule
`default_nettype wire
